// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_master transmitter among NUM_REQ on-chip producers.
//   A round-robin pick is made in IDLE. The winner's byte is latched and driven
//   to uart_master with en_tx. The arbiter then waits for u_tx_done. It returns
//   a one-cycle ack (or an err on timeout) to the winner. It then waits for done
//   to fall and holds an idle gap before the next arbitration.
//
// Ports
//   clk        in   1                system clock, rising edge
//   rst_n      in   1                asynchronous active-low reset
//   req        in   NUM_REQ          level request per requester
//   req_data   in   NUM_REQ*DATA_W   requester i byte at [i*DATA_W +: DATA_W]
//   ack        out  NUM_REQ          1-cycle pulse: frame completed
//   err        out  NUM_REQ          1-cycle pulse: frame timed out
//   tx_data    out  DATA_W           to uart_master.data, stable while en_tx=1
//   en_tx      out  1                to uart_master.en_tx
//   u_tx_done  in   1                from uart_master (pulse or level)
//   busy       out  1                high in every state except IDLE
//   grant_id   out  $clog2(NUM_REQ)  current / last granted requester
//   state_dbg  out  3                raw FSM state, for observation only
//
// Handshake: a requester raises req[i] with its byte on req_data and holds both.
// req is sampled only in IDLE, and the byte is captured at that moment. Exactly
// one of ack[i] or err[i] pulses for one cycle when the frame ends. The requester
// must drop req[i] in the following cycle, or it is treated as a new request.
// On the uart_master side, en_tx stays high with tx_data constant until
// u_tx_done is seen or the timeout expires.

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        err,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      en_tx,
  input  logic                      u_tx_done,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id,
  output logic [2:0]                state_dbg
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_BUSY    = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  // The counters are sized so that the width is at least 1 for the smallest
  // legal parameter values.
  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  logic [2:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  next_ptr;

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // The pointer rotates past the requester that was just served. NUM_REQ need
  // not be a power of two, so the wrap is explicit.
  assign next_ptr = (grant_id == ID_LAST) ? '0 : grant_id + ID_W'(1);

  // This is a round-robin search that starts at rr_ptr. The loop scans from the
  // farthest offset down to offset 0. The nearest set request at or after the
  // pointer is written last, so it wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ack      <= '0;
      err      <= '0;
      tx_data  <= '0;
      en_tx    <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      to_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      // ack and err are pulses. Every state clears them unless it sets one bit.
      ack <= '0;
      err <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            tx_data  <= req_data[pick_id*DATA_W +: DATA_W];
            state    <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          en_tx  <= 1'b1;
          to_cnt <= '0;
          state  <= ST_BUSY;
        end

        ST_BUSY: begin
          // done is checked first, so a done that arrives on the final
          // timeout cycle still completes the frame normally.
          if (u_tx_done) begin
            en_tx         <= 1'b0;
            ack[grant_id] <= 1'b1;
            rr_ptr        <= next_ptr;
            state         <= ST_RELEASE;
          end else if (to_cnt == TO_LAST) begin
            en_tx         <= 1'b0;
            err[grant_id] <= 1'b1;
            rr_ptr        <= next_ptr;
            state         <= ST_RELEASE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_RELEASE: begin
          // uart_master may hold done as a level. The arbiter waits for it to
          // fall so that the same done cannot complete the next frame.
          if (!u_tx_done) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          en_tx <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed scenarios (single frame, round-robin, level done, timeout,
//   done/timeout collision, reset mid-frame), followed by a randomized run.
//   The expected grant order, bytes and ack/err pulses come from a small model:
//   a rotating pointer scanned over the request mask.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 64;
  localparam int GAP_CYC     = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         tx_data;
  logic                      en_tx;
  logic                      u_tx_done;
  logic                      busy;
  logic [1:0]                grant_id;
  logic [2:0]                state_dbg;

  int total = 0;
  int bad   = 0;
  int rr_model = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .tx_data(tx_data), .en_tx(en_tx),
    .u_tx_done(u_tx_done), .busy(busy), .grant_id(grant_id),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The model pick returns the first set request at or after pointer p, with wrap.
  function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [DATA_W-1:0] d);
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req       = '0;
    u_tx_done = 1'b0;
    tick;
    tick;
    rst_n    = 1'b1;
    rr_model = 0;
    tick;
  endtask

  // One frame is run from the current request mask. The task waits for en_tx
  // and checks the grant and the byte. It then either answers with done after
  // done_delay cycles (held for done_len cycles) or lets the frame time out.
  // lat returns how many cycles it waited for en_tx.
  task automatic run_frame(input int done_delay, input int done_len,
                           input bit timeout, input bit scramble, output int lat);
    int id;
    logic [DATA_W-1:0] exp_d;
    logic [NUM_REQ-1:0] exp_bit;
    id  = pick(req, rr_model);
    lat = 0;
    if (id < 0) begin
      check("model_req_empty", 32'(req), 32'hF);
      return;
    end
    exp_d   = req_data[id*DATA_W +: DATA_W];
    exp_bit = NUM_REQ'(1) << id;
    while (en_tx !== 1'b1 && lat < 60) begin
      tick;
      lat++;
    end
    check("en_tx_rise", 32'(en_tx), 32'd1);
    if (en_tx !== 1'b1) return;
    check("grant_id", 32'(grant_id), 32'(id));
    check("tx_data", 32'(tx_data), 32'(exp_d));
    check("busy_frame", 32'(busy), 32'd1);
    if (scramble) begin
      for (int i = 0; i < NUM_REQ; i++) set_data(i, DATA_W'($urandom));
      req = req | NUM_REQ'($urandom_range(0, 15));
    end
    if (timeout) begin
      for (int i = 1; i < TIMEOUT_CYC; i++) begin
        tick;
        if (err !== '0 || ack !== '0 || en_tx !== 1'b1) begin
          check("early_end", {ack, err, 3'b0, en_tx}, 32'h1);
          break;
        end
      end
      check("to_data_stable", 32'(tx_data), 32'(exp_d));
      tick;
      check("to_err", 32'(err), 32'(exp_bit));
      check("to_no_ack", 32'(ack), 32'd0);
      check("to_en_low", 32'(en_tx), 32'd0);
      req[id] = 1'b0;
      rr_model = (id + 1) % NUM_REQ;
      tick;
      check("to_err_pulse", 32'({ack, err}), 32'd0);
    end else begin
      repeat (done_delay) tick;
      check("en_tx_held", 32'(en_tx), 32'd1);
      check("data_stable", 32'(tx_data), 32'(exp_d));
      u_tx_done = 1'b1;
      tick;
      check("ack", 32'(ack), 32'(exp_bit));
      check("no_err", 32'(err), 32'd0);
      check("en_tx_drop", 32'(en_tx), 32'd0);
      req[id] = 1'b0;
      rr_model = (id + 1) % NUM_REQ;
      for (int i = 1; i < done_len; i++) begin
        tick;
        check("level_single_ack", 32'({ack, err}), 32'd0);
      end
      u_tx_done = 1'b0;
      tick;
      check("ack_pulse", 32'({ack, err}), 32'd0);
      check("busy_release", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    u_tx_done = 1'b0;
    #3;
    // The reset state is checked while rst_n is still low.
    check("rst_en_tx", 32'(en_tx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_err", 32'({ack, err}), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    do_reset;

    // T1: single request, with en_tx expected two clocks after req.
    set_data(0, 8'h19);
    req = 4'b0001;
    tick;
    check("t1_lat1_en", 32'(en_tx), 32'd0);
    check("t1_lat1_busy", 32'(busy), 32'd1);
    tick;
    check("t1_lat2_en", 32'(en_tx), 32'd1);
    check("t1_data", 32'(tx_data), 32'h19);
    run_frame(40, 1, 1'b0, 1'b0, lat);
    repeat (5) tick;
    check("t1_idle", 32'(busy), 32'd0);

    // T2: round-robin from a fresh pointer
    do_reset;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'hA0 + 8'(i));
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      check("t2_model_order", 32'(pick(req, rr_model)), 32'(i));
      run_frame(3, 1, 1'b0, 1'b0, lat);
    end
    req = 4'b0001;
    run_frame(2, 1, 1'b0, 1'b0, lat);

    // T3: done is held as a level, and the gap after done falls is checked.
    set_data(1, 8'h5C);
    set_data(2, 8'h3E);
    req = 4'b0110;
    run_frame(5, 20, 1'b0, 1'b0, lat);
    run_frame(4, 1, 1'b0, 1'b0, lat);
    check("t3_gap_min", 32'((lat + 1) >= (GAP_CYC + 2)), 32'd1);

    // T4: timeout, after which the next requester is served.
    set_data(3, 8'h77);
    set_data(0, 8'h11);
    req = 4'b1001;
    run_frame(0, 1, 1'b1, 1'b0, lat);
    run_frame(7, 1, 1'b0, 1'b0, lat);

    // T5: done arrives on the last timeout cycle, so only ack is expected.
    set_data(2, 8'hC3);
    req = 4'b0100;
    run_frame(TIMEOUT_CYC - 1, 1, 1'b0, 1'b0, lat);

    // T6: reset is asserted in BUSY cycle 10.
    repeat (6) tick;
    set_data(1, 8'h42);
    req = 4'b0010;
    lat = 0;
    while (en_tx !== 1'b1 && lat < 60) begin
      tick;
      lat++;
    end
    check("t6_en_tx", 32'(en_tx), 32'd1);
    repeat (9) tick;
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("t6_async_en", 32'(en_tx), 32'd0);
    check("t6_ack_err", 32'({ack, err}), 32'd0);
    check("t6_grant", 32'(grant_id), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    tick;
    rst_n    = 1'b1;
    rr_model = 0;
    tick;
    set_data(2, 8'h9D);
    req = 4'b0100;
    run_frame(5, 1, 1'b0, 1'b0, lat);

    // The randomized run uses random masks, bytes and done timing, with
    // occasional timeouts.
    for (int n = 0; n < 30; n++) begin
      if (req == '0) begin
        int b;
        b = $urandom_range(0, NUM_REQ - 1);
        set_data(b, DATA_W'($urandom));
        req[b] = 1'b1;
      end
      if ($urandom_range(0, 7) == 0)
        run_frame(0, 1, 1'b1, 1'b1, lat);
      else
        run_frame($urandom_range(0, TIMEOUT_CYC - 1), $urandom_range(1, 3),
                  1'b0, 1'b1, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
